// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for ram_sync_clr.
package ram_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 9;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_IDLE  = 1'b1;

endpackage

// File: rtl/ram_array.sv
// Plain word storage: one write port plus a registered, read-first read port.
module ram_array #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage is not reset; the owner clears it with a sweep.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Non-blocking read in the same cycle as a write returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM that zero-fills itself after every reset and
// reports requests that arrive during the fill.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r,
  input  logic              w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  o,
  output logic              o_valid,
  output logic              busy,
  output logic              drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_valid;
  logic              r_drop;

  logic              w_clearing;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic              w_re;

  assign w_clearing = (r_state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
    end else if (w_clearing) begin
      r_valid <= 1'b0;
      r_drop  <= r | w;
      if (r_clr_cnt == LAST_ADDR) begin
        r_state   <= ST_IDLE;
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end
    end else begin
      r_valid <= r;
      r_drop  <= 1'b0;
    end
  end

  // Sweep owns the write port while clearing; user writes otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = addr;
    w_wdata = D;
    if (!rst) begin
      if (w_clearing) begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
      end else begin
        w_we = w;
      end
    end
  end

  assign w_re = r & ~w_clearing & ~rst;

  ram_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (addr),
    .o_rdata (o)
  );

  assign o_valid = r_valid;
  assign busy    = w_clearing;
  assign drop    = r_drop;

endmodule
